modmult_interleaved: RTL and testbench

- Parametrised modular multiplier: result = (a * b) mod n for WIDTH-bit unsigned operands. Radix-2 interleaved shift-add-subtract; no full-width product, no separate divider.
- Accepts any b, including b >= n: a built-in pre-reduction phase computes b mod n first.
- Successor to the fixed 32-bit multiply-then-modulo block. Used by the RSA modular-exponentiation controller for square and multiply steps.
- Single clock, start/busy/done handshake, explicit error for n == 0.

---
 rtl/modmult_interleaved.sv | 187 ++++++++++++++++++
 tb/tb_modmult_interleaved.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modmult_interleaved.sv
// Radix-2 interleaved modular multiplier: result = (a * b) mod n, any b (pre-reduced internally).
// Latency: done pulses 2*WIDTH+1 edges after the accepting edge (1 edge when n == 0).
// Backpressure: start is only sampled in IDLE; requests while busy or in DONE are dropped.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset, aborts any operation without a done pulse
//   start  - operation request, sampled in IDLE only
//   a, b   - operands (any value), n - modulus; all latched on the accepting edge
//   busy   - high from the accepting edge until the DONE-state edge
//   done   - one-cycle pulse, result/error valid
//   error  - raised with done when n == 0, held until the next accepted start
//   result - (a*b) mod n, held until the next accepted start
module modmult_interleaved #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result
);

    // Accumulator width: two guard bits so 2P + b_red (<= 3n-3) never overflows.
    localparam int PW = WIDTH + 2;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REDUCE = 2'd1;
    localparam logic [1:0] S_MULT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] n_q,      n_d;
    logic [WIDTH-1:0] bred_q,   bred_d;
    logic [PW-1:0]    p_q,      p_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             error_q,  error_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Modulus and twice the modulus, zero-extended to accumulator width.
    logic [PW-1:0] n_ext;
    logic [PW-1:0] n2_ext;
    assign n_ext  = {2'b00, n_q};
    assign n2_ext = {1'b0, n_q, 1'b0};

    logic last_bit;
    assign last_bit = (cnt_q == '0);

    // Reduction step: shift in the next bit of b. Since P < n, 2P+1 <= 2n-1,
    // so at most one subtraction brings it back below n.
    logic [PW-1:0] red_sum;
    logic [PW-1:0] red_next;
    always_comb begin
        red_sum  = (p_q << 1) + PW'(b_q[cnt_q]);
        red_next = red_sum;
        if (red_sum >= n_ext) begin
            red_next = red_sum - n_ext;
        end
    end

    // Multiply step: T = 2P + a_bit*b_red <= 3n-3, so subtract 2n or n at most once.
    logic [PW-1:0] mul_sum;
    logic [PW-1:0] mul_next;
    always_comb begin
        mul_sum  = (p_q << 1) + (a_q[cnt_q] ? {2'b00, bred_q} : '0);
        mul_next = mul_sum;
        if (mul_sum >= n2_ext) begin
            mul_next = mul_sum - n2_ext;
        end else if (mul_sum >= n_ext) begin
            mul_next = mul_sum - n_ext;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        bred_d   = bred_q;
        p_d      = p_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = error_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    n_d     = n;
                    p_d     = '0;
                    cnt_d   = CNT_TOP;
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                    // A zero modulus skips straight to DONE and reports an error there.
                    state_d = (n == '0) ? S_DONE : S_REDUCE;
                end
            end

            S_REDUCE: begin
                if (last_bit) begin
                    bred_d  = red_next[WIDTH-1:0];
                    p_d     = '0;
                    cnt_d   = CNT_TOP;
                    state_d = S_MULT;
                end else begin
                    p_d   = red_next;
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_MULT: begin
                p_d = mul_next;
                if (last_bit) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (n_q == '0) begin
                    error_d  = 1'b1;
                    result_d = '0;
                end else begin
                    result_d = p_q[WIDTH-1:0];
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            bred_q   <= '0;
            p_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            bred_q   <= bred_d;
            p_q      <= p_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;
    assign result = result_q;

endmodule

// File: tb/tb_modmult_interleaved.sv
// Bench for modmult_interleaved: one 8-bit and one 32-bit instance checked every cycle
// against a transaction-level model ((a*b)%n with fixed latency), plus literal spot checks.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_modmult_interleaved;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;

    logic       s8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, n8 = '0;
    logic       busy8, done8, err8;
    logic [7:0] r8;

    logic        s32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, n32 = '0;
    logic        busy32, done32, err32;
    logic [31:0] r32;

    modmult_interleaved #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(s8), .a(a8), .b(b8), .n(n8),
        .busy(busy8), .done(done8), .error(err8), .result(r8)
    );

    modmult_interleaved #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(s32), .a(a32), .b(b32), .n(n32),
        .busy(busy32), .done(done32), .error(err32), .result(r32)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference models ----------------
    // An accepted request completes a fixed number of edges later; until then
    // further requests are dropped. Outputs follow from (a*b) % n.
    int unsigned k8 = 0, dedge8 = 0;
    bit          pend8 = 0, perr8 = 0;
    logic [7:0]  pres8 = '0;
    logic        e_busy8 = 0, e_done8 = 0, e_err8 = 0;
    logic [7:0]  e_res8 = '0;

    always @(posedge clk) begin
        if (reset) begin
            pend8 = 0; e_busy8 = 0; e_done8 = 0; e_err8 = 0; e_res8 = '0;
        end else begin
            e_done8 = 0;
            if (pend8 && k8 == dedge8) begin
                pend8 = 0; e_done8 = 1; e_busy8 = 0; e_err8 = perr8; e_res8 = pres8;
            end else if (!pend8 && s8) begin
                pend8 = 1; e_busy8 = 1; e_err8 = 0;
                perr8 = (n8 == 8'd0);
                if (perr8) pres8 = '0;
                else pres8 = 8'((16'(a8) * 16'(b8)) % 16'(n8));
                dedge8 = k8 + (perr8 ? 1 : 17);
            end
        end
        k8++;
    end

    int unsigned k32 = 0, dedge32 = 0;
    bit          pend32 = 0, perr32 = 0;
    logic [31:0] pres32 = '0;
    logic        e_busy32 = 0, e_done32 = 0, e_err32 = 0;
    logic [31:0] e_res32 = '0;

    always @(posedge clk) begin
        if (reset) begin
            pend32 = 0; e_busy32 = 0; e_done32 = 0; e_err32 = 0; e_res32 = '0;
        end else begin
            e_done32 = 0;
            if (pend32 && k32 == dedge32) begin
                pend32 = 0; e_done32 = 1; e_busy32 = 0; e_err32 = perr32; e_res32 = pres32;
            end else if (!pend32 && s32) begin
                pend32 = 1; e_busy32 = 1; e_err32 = 0;
                perr32 = (n32 == 32'd0);
                if (perr32) pres32 = '0;
                else pres32 = 32'((64'(a32) * 64'(b32)) % 64'(n32));
                dedge32 = k32 + (perr32 ? 1 : 65);
            end
        end
        k32++;
    end

    // ---------------- every-cycle compare ----------------
    always @(negedge clk) begin
        check("busy8",    busy8,  e_busy8);
        check("done8",    done8,  e_done8);
        check("error8",   err8,   e_err8);
        check("result8",  r8,     e_res8);
        check("busy32",   busy32, e_busy32);
        check("done32",   done32, e_done32);
        check("error32",  err32,  e_err32);
        check("result32", r32,    e_res32);
    end

    // ---------------- directed helpers ----------------
    // Issues one request; lat = edges from the accepting edge to the edge raising done,
    // bcnt = sampled cycles with busy high. poke >= 0 re-asserts start with junk
    // operands at that point of the operation.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n,
                        input int poke, output logic [7:0] res, output logic err,
                        output int lat, output int bcnt);
        @(negedge clk);
        a8 = a; b8 = b; n8 = n; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0; lat = 0; bcnt = 0;
        while (!done8 && lat < 300) begin
            if (busy8) bcnt++;
            s8 = (lat == poke);
            if (lat == poke) begin
                a8 = 8'($urandom); b8 = 8'($urandom); n8 = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        s8 = 1'b0;
        if (!done8) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout8: no done within %0d cycles, expected done", lat);
        end
        res = r8; err = err8;
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n,
                         output logic [31:0] res, output logic err, output int lat);
        @(negedge clk);
        a32 = a; b32 = b; n32 = n; s32 = 1'b1;
        @(negedge clk);
        s32 = 1'b0; lat = 0;
        while (!done32 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!done32) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout32: no done within %0d cycles, expected done", lat);
        end
        res = r32; err = err32;
    endtask

    function automatic logic [31:0] rnd_val();
        int unsigned sel;
        sel = $urandom_range(0, 15);
        case (sel)
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3, 4:    return 32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // ---------------- main sequence ----------------
    logic [7:0]  res8;
    logic [31:0] res32;
    logic        err;
    int          lat, bcnt;

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Basic op: latency and busy width.
        run8(8'd7, 8'd9, 8'd11, -1, res8, err, lat, bcnt);
        check("d8_7x9m11_res", res8, 8'd8);
        check("d8_7x9m11_err", err, 1'b0);
        check("d8_7x9m11_lat", lat, 17);
        check("d8_7x9m11_busy", bcnt, 17);

        // b >= n, operands above n.
        run8(8'd5, 8'd200, 8'd13, -1, res8, err, lat, bcnt);
        check("d8_5x200m13", res8, 8'd12);

        // Zero modulus: error after one cycle, then cleared by a normal op.
        run8(8'd3, 8'd4, 8'd0, -1, res8, err, lat, bcnt);
        check("d8_n0_res", res8, 8'd0);
        check("d8_n0_err", err, 1'b1);
        check("d8_n0_lat", lat, 1);
        run8(8'd7, 8'd9, 8'd11, -1, res8, err, lat, bcnt);
        check("d8_after_n0_err", err, 1'b0);
        check("d8_after_n0_res", res8, 8'd8);

        run8(8'd200, 8'd100, 8'd1, -1, res8, err, lat, bcnt);
        check("d8_n1", res8, 8'd0);
        run8(8'd0, 8'd100, 8'd97, -1, res8, err, lat, bcnt);
        check("d8_a0", res8, 8'd0);

        // Start re-asserted mid-operation with junk operands is ignored.
        run8(8'd255, 8'd255, 8'd251, 5, res8, err, lat, bcnt);
        check("d8_poke_res", res8, 8'd16);
        check("d8_poke_lat", lat, 17);

        // Start held high: consecutive ops every 2*WIDTH+2 cycles.
        begin
            int t = 0, t1 = -1, t2 = -1;
            @(negedge clk);
            a8 = 8'd7; b8 = 8'd9; n8 = 8'd11; s8 = 1'b1;
            while (t2 < 0 && t < 200) begin
                @(negedge clk);
                t++;
                if (done8) begin
                    if (t1 < 0) t1 = t; else t2 = t;
                    check("d8_held_res", r8, 8'd8);
                end
            end
            s8 = 1'b0;
            check("d8_held_gap", t2 - t1, 18);
            repeat (20) @(negedge clk);
        end

        // Reset in the middle of MULT: outputs cleared, no done pulse.
        run8(8'd255, 8'd255, 8'd251, -1, res8, err, lat, bcnt);
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd100; n8 = 8'd201; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("d8_rst_busy", busy8, 1'b0);
        check("d8_rst_done", done8, 1'b0);
        check("d8_rst_res", r8, 8'd0);
        begin
            int seen = 0;
            repeat (30) begin
                @(negedge clk);
                if (done8) seen++;
            end
            check("d8_rst_no_done", seen, 0);
        end
        run8(8'd5, 8'd200, 8'd13, -1, res8, err, lat, bcnt);
        check("d8_after_rst", res8, 8'd12);

        // 32-bit directed cases.
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, res32, err, lat);
        check("d32_max_res", res32, 32'd16);
        check("d32_max_lat", lat, 65);
        run32(32'd123456789, 32'd987654321, 32'd1000000007, res32, err, lat);
        check("d32_big", res32, (64'd123456789 * 64'd987654321) % 64'd1000000007);
        run32(32'd123456789, 32'd987654321, 32'd1, res32, err, lat);
        check("d32_n1", res32, 32'd0);
        run32(32'd0, 32'd987654321, 32'd1000000007, res32, err, lat);
        check("d32_a0", res32, 32'd0);
        run32(32'd5, 32'd6, 32'd0, res32, err, lat);
        check("d32_n0_err", err, 1'b1);
        check("d32_n0_lat", lat, 1);

        // Randomized traffic on both instances; the every-cycle compare does the checking.
        fork
            begin
                repeat (30000) begin
                    @(negedge clk);
                    s8 = ($urandom_range(0, 1) == 1);
                    a8 = 8'(rnd_val()); b8 = 8'(rnd_val()); n8 = 8'(rnd_val());
                end
                s8 = 1'b0;
            end
            begin
                repeat (30000) begin
                    @(negedge clk);
                    s32 = ($urandom_range(0, 1) == 1);
                    a32 = rnd_val(); b32 = rnd_val(); n32 = rnd_val();
                end
                s32 = 1'b0;
            end
        join
        repeat (80) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
